// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - first-word-fall-through byte FIFO for the UART host/controller paths
// Optional sticky overflow/underflow flags are built when UART_FIFO_ERR_FLAGS_EN is defined.
module uart_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  output logic              afull_o,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o
`ifdef UART_FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow_o,
  output logic              underflow_o
`endif
);

  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'(AFULL_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic              wr_acc;
  logic              rd_acc;

  // Status decodes only from registered state, never from the strobes.
  assign full_o    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign empty_o   = (wr_ptr == rd_ptr);
  assign afull_o   = (level_q >= AFULL_LVL);
  assign level_o   = level_q;
  assign rd_data_o = mem[rd_ptr[ADDR_W-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign wr_acc = wr_en_i && (!full_o || rd_en_i);
  assign rd_acc = rd_en_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (wr_acc && !clr_i) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clr_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + PTR_ONE;
        2'b01:   level_q <= level_q - PTR_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef UART_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clr_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_en_i && !wr_acc) begin
        overflow_o <= 1'b1;
      end
      if (rd_en_i && !rd_acc) begin
        underflow_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - directed self-checking bench for uart_fifo
// Flag checks are compiled in only when UART_FIFO_ERR_FLAGS_EN is defined.
module tb_uart_fifo;

  logic       tb_clk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       clr    = 1'b0;
  logic       wr_en  = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en  = 1'b0;
  logic       full;
  logic       afull;
  logic [7:0] rd_data;
  logic       empty;
  logic [4:0] level;
`ifdef UART_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 tb_clk = ~tb_clk;

  uart_fifo #(
    .DATA_W(8),
    .DEPTH(16),
    .AFULL_THRESH(12)
  ) dut (
    .clk_i(tb_clk),
    .rst_ni(rst_n),
    .clr_i(clr),
    .wr_en_i(wr_en),
    .wr_data_i(wr_data),
    .full_o(full),
    .afull_o(afull),
    .rd_en_i(rd_en),
    .rd_data_o(rd_data),
    .empty_o(empty),
    .level_o(level)
`ifdef UART_FIFO_ERR_FLAGS_EN
    ,
    .overflow_o(overflow),
    .underflow_o(underflow)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    chk(tag, {31'd0, empty}, 32'd0);
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1; wr_en = 1'b0;
    step();
    rd_en = 1'b0;
  endtask

  logic [7:0] rx_q[$];

  initial begin
    #12;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_afull", {31'd0, afull}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
`ifdef UART_FIFO_ERR_FLAGS_EN
    chk("rst_ovf", {31'd0, overflow},  32'd0);
    chk("rst_udf", {31'd0, underflow}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Fill and drain
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk("fill_afull", {31'd0, afull}, (i + 1 >= 12) ? 32'd1 : 32'd0);
      chk("fill_level", {27'd0, level}, 32'(i + 1));
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) pop_check("drain_data", 8'(i));
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_level", {27'd0, level}, 32'd0);

    // Wrap-around
    for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) pop_check("wrap_pre", 8'h10 + 8'(i));
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    chk("wrap_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) pop_check("wrap_data", 8'hA0 + 8'(i));
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // Simultaneous write+read while full
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("sim_full_data", {24'd0, rd_data}, 32'h00);
    wr_en = 1'b1; wr_data = 8'h5A; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sim_full_level", {27'd0, level}, 32'd16);
    chk("sim_full_full",  {31'd0, full},  32'd1);
`ifdef UART_FIFO_ERR_FLAGS_EN
    chk("sim_full_ovf", {31'd0, overflow}, 32'd0);
`endif
    for (int i = 1; i < 16; i++) pop_check("sim_full_pop", 8'(i));
    pop_check("sim_full_last", 8'h5A);
    chk("sim_full_empty", {31'd0, empty}, 32'd1);

    // Simultaneous write+read while empty: only the write lands
    wr_en = 1'b1; wr_data = 8'h33; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sim_empty_level", {27'd0, level}, 32'd1);
    chk("sim_empty_data", {24'd0, rd_data}, 32'h33);
`ifdef UART_FIFO_ERR_FLAGS_EN
    chk("sim_empty_udf", {31'd0, underflow}, 32'd1);
`endif
    pop_check("sim_empty_pop", 8'h33);

    // Write while full with no read is dropped
    for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
    push(8'hEE);
    chk("ovf_level", {27'd0, level}, 32'd16);
`ifdef UART_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
`endif
    for (int i = 0; i < 16; i++) pop_check("ovf_pop", 8'hC0 + 8'(i));
    chk("ovf_empty", {31'd0, empty}, 32'd1);

    // Flush wins over a simultaneous write
    push(8'h01);
    push(8'h02);
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
    step();
    clr = 1'b0; wr_en = 1'b0;
    chk("clr_empty", {31'd0, empty}, 32'd1);
    chk("clr_level", {27'd0, level}, 32'd0);
`ifdef UART_FIFO_ERR_FLAGS_EN
    chk("clr_ovf", {31'd0, overflow},  32'd0);
    chk("clr_udf", {31'd0, underflow}, 32'd0);
`endif

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    chk("prerst_level", {27'd0, level}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_level", {27'd0, level}, 32'd0);
    chk("arst_full",  {31'd0, full},  32'd0);
    @(negedge tb_clk);
    rst_n = 1'b1;
    step();
    push(8'h77);
    pop_check("postrst_pop", 8'h77);
    chk("postrst_empty", {31'd0, empty}, 32'd1);

    // TX loopback: controller pops whenever the FIFO is non-empty
    push(8'h55);
    wr_en = 1'b1; wr_data = 8'hAA; rd_en = !empty;
    if (rd_en) rx_q.push_back(rd_data);
    step();
    wr_en = 1'b0;
    for (int c = 0; c < 20 && rx_q.size() < 2; c++) begin
      rd_en = !empty;
      if (rd_en) rx_q.push_back(rd_data);
      step();
    end
    rd_en = 1'b0;
    chk("loop_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() >= 2) begin
      chk("loop_rx0", {24'd0, rx_q[0]}, 32'h55);
      chk("loop_rx1", {24'd0, rx_q[1]}, 32'hAA);
    end
    chk("loop_empty", {31'd0, empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Synchronous first-word-fall-through byte FIFO that buffers data between a host and the UART controller. Instantiated twice per channel. On the TX side the host writes bytes and the controller pops them through its TX FIFO pop strobe. On the RX side the controller's RX FIFO push strobe writes received bytes and the host reads them. The FIFO provides level reporting, an almost-full threshold, and optional sticky error flags.

## Interface

Parameters:
- `DATA_W`, default 8: width of each entry. Matches `MAX_UART_DATA_W`.
- `DEPTH`, default 16: number of entries. Must be a power of two and ≥ 2.
- `ADDR_W`, default `$clog2(DEPTH)`: pointer index width. Derived; do not override.
- `AFULL_THRESH`, default 12: `afull_o` asserts when level ≥ this value. Legal range 1..`DEPTH`.

Ports:
- `clk_i`, in, 1: clock. All state changes on the rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `clr_i`, in, 1: synchronous flush. Empties the FIFO and clears error flags.
- `wr_en_i`, in, 1: write strobe.
- `wr_data_i`, in, `DATA_W`: write data.
- `full_o`, out, 1: level == `DEPTH`.
- `afull_o`, out, 1: level ≥ `AFULL_THRESH`.
- `rd_en_i`, in, 1: read/pop strobe.
- `rd_data_o`, out, `DATA_W`: head entry. Valid whenever `empty_o` = 0.
- `empty_o`, out, 1: level == 0.
- `level_o`, out, `ADDR_W+1`: current number of stored entries.
- `overflow_o`, out, 1: sticky. Set by a write while full. Present only with `UART_FIFO_ERR_FLAGS_EN`.
- `underflow_o`, out, 1: sticky. Set by a read while empty. Present only with `UART_FIFO_ERR_FLAGS_EN`.

## Operation

Storage and pointers:
- Storage is a `DEPTH` × `DATA_W` register array with a combinational read at the read pointer.
- Write and read pointers are `ADDR_W+1` bits. The low `ADDR_W` bits index the array; the MSB is the wrap bit.
  - Full: indices equal and MSBs differ.
  - Empty: pointers equal.
- `level_o` is the registered count, equal to `wr_ptr - rd_ptr` modulo 2^(`ADDR_W+1`). `full_o`, `empty_o` and `afull_o` decode from the registered pointers/level only, with no combinational path from the strobes.

Accepting writes and reads:
- A write is accepted when `wr_en_i` && (!`full_o` || `rd_en_i`). A write while full with a simultaneous read is accepted: the pop frees the slot in the same edge.
- A read is accepted when `rd_en_i` && !`empty_o`. There is no bypass: a simultaneous read and write while empty accepts only the write, and the read counts as an underflow.

Per-edge update:
- Write accepted: store `wr_data_i` at the write index, increment the write pointer.
- Read accepted: increment the read pointer.
- Both accepted: level is unchanged.
- A rejected write drops its data; the array and pointers are unchanged. A rejected read changes nothing.

Flush:
- `clr_i` has priority over both strobes in the same cycle.
- Pointers and level go to 0; with the macro defined, error flags also clear. Array contents are not cleared.

Reset:
- Asserting `rst_ni` at any time, including mid-operation, immediately zeroes the pointers, level and error flags. Array contents are undefined after reset and are never exposed while `empty_o` = 1.
- Reset values of the outputs:
  - `empty_o` = 1
  - `full_o` = 0
  - `afull_o` = 0
  - `level_o` = 0
  - `overflow_o` = 0
  - `underflow_o` = 0
  - `rd_data_o` = don't-care; verification must not check it while empty.

## Timing

- Write-to-read latency is 1 cycle. A write accepted at edge N causes `empty_o` to deassert and `rd_data_o` to present the data after edge N.
- Read is first-word-fall-through. `rd_data_o` is valid in the same cycle `rd_en_i` is sampled. After the edge, the next entry (or empty) is visible.
- Flags and level update on the edge that accepts the write or read, and are stable for the whole following cycle.
- This timing is compatible with the controller's single-cycle TX pop and RX push pulses. Consecutive pops on back-to-back cycles are supported.
- Pointer wrap from `DEPTH`-1 to 0 toggles the MSB; no extra cycle is spent.

## Configuration

- Macro `UART_FIFO_ERR_FLAGS_EN`.
- Defined: `overflow_o` and `underflow_o` exist as sticky registers.
  - They set on a rejected write or rejected read respectively.
  - They clear only on `rst_ni` or `clr_i`.
- Undefined: both ports and their registers are removed. Rejected accesses are silently ignored, and all other behaviour is identical.

## Test plan

1. **Fill and drain.** `DEPTH`=16, `AFULL_THRESH`=12. After reset, write 0x00..0x0F on consecutive cycles.
   - `afull_o` rises after the 12th write and `full_o` after the 16th; `level_o`=16.
   - Then pop 16 times: `rd_data_o` reads 0x00..0x0F in order, and `empty_o`=1 after the 16th pop.
2. **Wrap-around.** Write 10 entries and pop 10, then write 0xA0..0xAF (16 entries).
   - `full_o`=1, and the pops return 0xA0..0xAF in order across the index wrap.
3. **Simultaneous access at the boundaries.**
   - While full, assert `wr_en_i`=1 with 0x5A together with `rd_en_i`=1: both are accepted, level stays 16, 0x5A is the last entry popped, and `overflow_o` stays 0.
   - While empty, assert the same strobes with 0x33: level becomes 1, `rd_data_o`=0x33 on the next cycle, and `underflow_o`=1.
4. **Error flags** (`UART_FIFO_ERR_FLAGS_EN` defined).
   - Write 0xEE while full with no read: `overflow_o`=1, 0xEE is never read out, and the contents are unchanged.
   - `clr_i` pulse: both flags return to 0 and `empty_o`=1.
5. **Reset mid-operation.** Store 5 entries, then assert `rst_ni` low asynchronously between clock edges.
   - Outputs take their reset values immediately: `empty_o`=1, `level_o`=0.
   - After release, write 0x77: the next pop returns 0x77.
6. **Controller TX loopback.** Connect to the controller TX path (pop strobe → `rd_en_i`, `rd_data_o` → TX data, !`empty_o` → TX start) and write 0x55 then 0xAA.
   - The RX side receives 0x55 then 0xAA, and the FIFO is empty after the second pop.
